// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the picoMIPS execution controller.
package cpu_run_ctrl_pkg;

    // Controller mode as shown on the LEDs.
    typedef enum logic [1:0] {
        STEP   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } run_state_t;

    // Width of the issued-pulse counter.
    localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/cpu_run_ctrl_debounce.sv
// Counter-based debouncer: q follows d only after d has disagreed with q
// for 2^DEB_W consecutive cycles; any agreement restarts the count.
module debounce #(
    parameter int DEB_W = 16
) (
    input  logic fastclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEB_W-1:0] cnt;

    // Count consecutive disagreement cycles and flip q when the count saturates.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (&cnt) begin
            cnt <= '0;
            q   <= d;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller: issues single-cycle cpu_en pulses in free-run or
// single-step mode, stops on CPU halt, and synchronises the board switches.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV_W = 22,
    parameter int DEB_W = 16,
    parameter int SW_W  = 10
) (
    input  logic                  fastclk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  halt_in,
    input  logic [SW_W-1:0]       sw_raw,
    output logic [SW_W-1:0]       sw_sync,
    output logic                  cpu_en,
    output logic [1:0]            state,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    logic            run_p0, run_p1;
    logic            step_p0, step_p1;
    logic [SW_W-1:0] sw_p0;
    logic            deb_q, deb_prev, step_rise;
    run_state_t      st, st_nxt;
    logic [DIV_W-1:0] pre, pre_nxt;
    logic            wrap, wrap_nxt;
    logic            en_nxt;

    wire run_s = run_p1;

    // Two-flop synchronisers for the asynchronous run, step and switch inputs.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            run_p0  <= 1'b0;
            run_p1  <= 1'b0;
            step_p0 <= 1'b0;
            step_p1 <= 1'b0;
            sw_p0   <= '0;
            sw_sync <= '0;
        end else begin
            run_p0  <= run;
            run_p1  <= run_p0;
            step_p0 <= step;
            step_p1 <= step_p0;
            sw_p0   <= sw_raw;
            sw_sync <= sw_p0;
        end
    end

    debounce #(.DEB_W(DEB_W)) u_step_deb (
        .fastclk (fastclk),
        .reset   (reset),
        .d       (step_p1),
        .q       (deb_q)
    );

    // Registered rising-edge detector on the debounced step level.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            deb_prev  <= 1'b0;
            step_rise <= 1'b0;
        end else begin
            deb_prev  <= deb_q;
            step_rise <= deb_q & ~deb_prev;
        end
    end

    // Mode FSM register plus prescaler, wrap flag and the registered pulse.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            st     <= STEP;
            pre    <= '0;
            wrap   <= 1'b0;
            cpu_en <= 1'b0;
        end else begin
            st     <= st_nxt;
            pre    <= pre_nxt;
            wrap   <= wrap_nxt;
            cpu_en <= en_nxt;
        end
    end

    // Next-state logic; halt_in wins over run_s and step_rise, and leaving RUN
    // discards a wrap that was waiting to become a pulse.
    always_comb begin
        st_nxt   = st;
        pre_nxt  = pre;
        wrap_nxt = 1'b0;
        en_nxt   = 1'b0;
        case (st)
            STEP: begin
                if (halt_in) begin
                    st_nxt = HALTED;
                end else if (run_s) begin
                    st_nxt  = RUN;
                    pre_nxt = '0;
                end else if (step_rise) begin
                    en_nxt = 1'b1;
                end
            end
            RUN: begin
                if (halt_in) begin
                    st_nxt = HALTED;
                end else if (!run_s) begin
                    st_nxt = STEP;
                end else begin
                    pre_nxt  = pre + 1'b1;
                    wrap_nxt = &pre;
                    en_nxt   = wrap;
                end
            end
            HALTED: begin
                if (!run_s) begin
                    st_nxt = STEP;
                end
            end
            default: st_nxt = STEP;
        endcase
    end

    // Count issued pulses, wrapping naturally at the counter width.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (cpu_en) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with small prescaler/debounce widths.
module tb_cpu_run_ctrl;

    localparam int DIV_W = 3;
    localparam int DEB_W = 2;
    localparam int SW_W  = 10;
    localparam int PER   = 1 << DIV_W;   // free-run period
    localparam int STEP_LAT = 2 + (1 << DEB_W) + 1 + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            run = 1'b0;
    logic            step = 1'b0;
    logic            halt_in = 1'b0;
    logic [SW_W-1:0] sw_raw = '0;
    logic [SW_W-1:0] sw_sync;
    logic            cpu_en;
    logic [1:0]      state;
    logic [15:0]     step_cnt;

    cpu_run_ctrl #(.DIV_W(DIV_W), .DEB_W(DEB_W), .SW_W(SW_W)) dut (
        .fastclk  (clk),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .halt_in  (halt_in),
        .sw_raw   (sw_raw),
        .sw_sync  (sw_sync),
        .cpu_en   (cpu_en),
        .state    (state),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_cyc_q[$];
    logic [15:0] exp_cnt_q[$];
    logic [15:0] exp_cnt = '0;
    logic        prev_en = 1'b0;
    int          mon_t;
    logic [15:0] mon_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pulse(input int t);
        exp_cyc_q.push_back(t);
        exp_cnt_q.push_back(exp_cnt);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    // Monitor: every observed pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            chk("en_back_to_back", {31'b0, prev_en}, 32'd0);
            if (exp_cyc_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_t = exp_cyc_q.pop_front();
                mon_c = exp_cnt_q.pop_front();
                chk("pulse_cycle", cyc, mon_t);
                chk("pulse_step_cnt", {16'b0, step_cnt}, {16'b0, mon_c});
            end
        end
        prev_en = cpu_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        step = 1'b0;
        halt_in = 1'b0;
        tick(2);
        reset = 1'b0;
        exp_cyc_q.delete();
        exp_cnt_q.delete();
        exp_cnt = '0;
        tick(1);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_cyc_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("pulses_outstanding", exp_cyc_q.size(), 32'd0);
    endtask

    task automatic press_step(input int nbounce);
        for (int b = 0; b < nbounce; b++) begin
            step = 1'b1;
            tick($urandom_range(1, 3));
            step = 1'b0;
            tick($urandom_range(1, 3));
        end
        step = 1'b1;
        push_pulse(cyc + STEP_LAT);
        tick(20);
        step = 1'b0;
        tick(12);
    endtask

    initial begin
        int n0, np, r, m, k, t;
        logic [SW_W-1:0] old_sw, v;

        // Reset state and idle behaviour.
        do_reset();
        chk("rst_state", state, 32'd0);
        chk("rst_cpu_en", cpu_en, 32'd0);
        chk("rst_step_cnt", step_cnt, 32'd0);
        chk("rst_sw_sync", sw_sync, 32'd0);
        tick(50);
        drain();

        // Switch synchroniser lag.
        old_sw = sw_raw;
        for (int i = 0; i < 5; i++) begin
            v = (i == 0) ? 10'h2A5 : SW_W'($urandom);
            if (v == old_sw) v = ~old_sw;
            sw_raw = v;
            tick(1);
            chk("sw_sync_lag1", sw_sync, old_sw);
            tick(1);
            chk("sw_sync_lag2", sw_sync, v);
            tick(1);
            old_sw = v;
        end

        // Free-run with a randomly timed exit, including a dropped pending wrap.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            n0 = cyc;
            run = 1'b1;
            tick(2);
            chk("run_state_early", state, 32'd0);
            tick(1);
            chk("run_state_entered", state, 32'd1);
            np = (it == 0) ? 4 : $urandom_range(3, 6);
            r  = (it == 1) ? 5 : $urandom_range(0, 7);
            m  = n0 + 3 + PER + 1 + PER * (np - 1) + r;
            for (int j = 0; j < 20; j++) begin
                t = n0 + 3 + PER + 1 + PER * j;
                if (t <= m + 2) push_pulse(t);
            end
            wait_cyc(m);
            run = 1'b0;
            tick(2);
            chk("run_exit_state_hold", state, 32'd1);
            tick(1);
            chk("run_exit_state_step", state, 32'd0);
            tick(1);
            chk("run_total_cnt", step_cnt, {16'b0, exp_cnt});
            tick(10);
            drain();
        end

        // Single-step presses with bounce; step ignored count check.
        do_reset();
        press_step(2);
        for (int p = 0; p < int'($urandom_range(1, 2)); p++) press_step($urandom_range(1, 3));
        drain();
        chk("step_total_cnt", step_cnt, {16'b0, exp_cnt});

        // Halt at a prescaler wrap, stay halted, then recover via STEP.
        do_reset();
        n0 = cyc;
        run = 1'b1;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) push_pulse(n0 + 3 + PER + 1 + PER * j);
        wait_cyc(n0 + 3 + PER - 1 + PER * k);
        halt_in = 1'b1;
        tick(1);
        chk("halt_state", state, 32'd2);
        halt_in = 1'b0;
        tick($urandom_range(3, 10));
        chk("halt_hold_state", state, 32'd2);
        run = 1'b0;
        tick(3);
        chk("halt_to_step_state", state, 32'd0);
        press_step(1);
        drain();
        chk("halt_total_cnt", step_cnt, {16'b0, exp_cnt});

        // Reset asserted while a RUN pulse is high.
        do_reset();
        n0 = cyc;
        run = 1'b1;
        push_pulse(n0 + 3 + PER + 1);
        wait_cyc(n0 + 3 + PER + 1);
        reset = 1'b1;
        run = 1'b0;
        tick(1);
        chk("midrst_cpu_en", cpu_en, 32'd0);
        chk("midrst_step_cnt", step_cnt, 32'd0);
        chk("midrst_state", state, 32'd0);
        reset = 1'b0;
        exp_cnt = '0;
        tick(20);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
